// File: rtl/onchip_mem_test_master_pkg.sv
// Shared types and helpers for the on-chip memory self-test master:
// FSM state encoding, LFSR taps/step function and error-counter ceiling.
package onchip_mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [15:0] ERR_MAX   = 16'hFFFF;

  // 32-bit Galois LFSR, right-shifting
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM single-port RAM slave bus as driven by the memory self-test master.
interface onchip_mem_test_master_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                clken;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_test_master_lfsr.sv
// Pattern generator for the memory self-test: seed load, advance enable, value out.
module onchip_mem_test_lfsr
  import onchip_mem_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value
);

  localparam logic [31:0] SEED_EFF = seed_fix(SEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (load) begin
      value <= SEED_EFF;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/onchip_mem_test_master.sv
// Avalon-MM memory self-test initiator: LFSR fill, readback and compare of DEPTH words.
// Define MEMTEST_INVERT_PASS_EN to add a second pass using the inverted pattern.
module onchip_mem_test_master
  import onchip_mem_test_pkg::*;
#(
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 80000,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] SEED         = 32'h00000001
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    pause,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [DATA_W-1:0]       fail_data,
  onchip_mem_test_master_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam int unsigned       CNT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              cs_q;
  logic              wr_q;
  logic              invert_q;
  logic [CNT_W-1:0]  drain_cnt;
  logic              run;
  logic              at_last;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [31:0]       lfsr_val;
  logic [DATA_W-1:0] pattern;

  logic [READ_LATENCY-1:0]             pipe_vld;
  logic [READ_LATENCY-1:0][ADDR_W-1:0] pipe_addr;
  logic [READ_LATENCY-1:0][DATA_W-1:0] pipe_exp;
  logic                                mismatch;

  // pause freezes everything except an idle master
  assign run      = !(pause && (state != IDLE));
  assign at_last  = (addr_q == LAST_ADDR);
  assign pattern  = lfsr_val[DATA_W-1:0] ^ {DATA_W{invert_q}};
  assign mismatch = run && pipe_vld[READ_LATENCY-1] &&
                    (bus.readdata != pipe_exp[READ_LATENCY-1]);

  assign bus.address    = addr_q;
  assign bus.byteenable = '1;
  assign bus.chipselect = cs_q;
  assign bus.write      = wr_q;
  assign bus.writedata  = wr_q ? pattern : '0;
  assign bus.clken      = ~pause;

  // Reseeding at the end of every sweep lets READ and a following WRITE restart cleanly
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state)
      IDLE:        lfsr_load = start && !done;
      WRITE, READ: begin
        if (run) begin
          lfsr_load = at_last;
          lfsr_adv  = !at_last;
        end
      end
      default:     ;
    endcase
  end

  onchip_mem_test_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (reset_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
    end else if (run) begin
      pipe_vld[0] <= (state == READ);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (run) begin
      pipe_addr[0] <= addr_q;
      pipe_exp[0]  <= pattern;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
    end
  end

`ifndef MEMTEST_INVERT_PASS_EN
  assign invert_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef MEMTEST_INVERT_PASS_EN
      invert_q  <= 1'b0;
`endif
    end else if (run) begin
      done <= 1'b0;
      if (mismatch) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 16'd1;
        end
        if (err_count == '0) begin
          fail_addr <= pipe_addr[READ_LATENCY-1];
          fail_data <= bus.readdata;
        end
      end
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            state     <= WRITE;
            addr_q    <= '0;
            cs_q      <= 1'b1;
            wr_q      <= 1'b1;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef MEMTEST_INVERT_PASS_EN
            invert_q  <= 1'b0;
`endif
          end
        end
        WRITE: begin
          if (at_last) begin
            state  <= READ;
            addr_q <= '0;
            wr_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        READ: begin
          if (at_last) begin
            state     <= DRAIN;
            cs_q      <= 1'b0;
            drain_cnt <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
`ifdef MEMTEST_INVERT_PASS_EN
            if (!invert_q) begin
              state    <= WRITE;
              invert_q <= 1'b1;
              addr_q   <= '0;
              cs_q     <= 1'b1;
              wr_q     <= 1'b1;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_test_master.md
Name: onchip_mem_test_master

Overview:
- Avalon-MM initiator that drives the single-port on-chip RAM slave: address, byteenable, chipselect, write, writedata, clken; it samples readdata.
- On start it fills DEPTH words with an LFSR pattern, reads them back and compares each word against a regenerated expected value.
- Reports pass/fail, error count and first failing address/data.
- Sits beside the Nios bus as a power-on/debug memory self-test, muxed onto the RAM slave port while busy.

Parameters:
- ADDR_W, 17, address width of the RAM slave.
- DATA_W, 32, data width (byteenable width = DATA_W/8).
- DEPTH, 80000, number of words tested, addresses 0..DEPTH-1.
- READ_LATENCY, 1, fixed cycles from read address to valid readdata (slave has no waitrequest).
- SEED, 32'h00000001, LFSR seed; 0 is replaced by 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins test when idle
- pause  in  1  freezes test and RAM (clken low)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at test end
- pass  out  1  valid from done until next start; 1 = zero errors
- err_count  out  16  mismatching words, saturates at 16'hFFFF
- fail_addr  out  ADDR_W  address of first mismatch
- fail_data  out  DATA_W  readdata of first mismatch
- address  out  ADDR_W  RAM address
- byteenable  out  DATA_W/8  all ones during writes and reads
- chipselect  out  1  RAM select
- write  out  1  RAM write strobe
- writedata  out  DATA_W  RAM write data
- readdata  in  DATA_W  RAM read data
- clken  out  1  RAM clock enable = ~pause

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0 except byteenable = all ones and clken = 1.
  - FSM goes to IDLE; LFSR = SEED.
  - Reset mid-test deasserts chipselect/write immediately; no result is reported.
- LFSR: 32-bit Galois, right shift, taps 32'h80200003: next = (l>>1) ^ (l[0] ? 32'h80200003 : 0). writedata = low DATA_W bits.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE: start=1 -> WRITE. Load address=0 and LFSR=SEED; clear err_count, fail_*, pass; busy=1.
  - WRITE: chipselect=1, write=1, writedata=LFSR. Each unpaused cycle advances address and LFSR. After address DEPTH-1: address=0, reseed LFSR, go to READ.
  - READ: chipselect=1, write=0. Each cycle pushes LFSR value (expected) and address into a READ_LATENCY-deep shift pipeline. After address DEPTH-1 go to DRAIN.
  - DRAIN: chipselect=0; wait READ_LATENCY cycles for the pipeline to empty -> DONE.
  - DONE: one cycle. done=1, busy=0, pass=(err_count==0) -> IDLE.
- Compare: when a pipeline stage exits valid and readdata != expected:
  - err_count increments, saturating.
  - On the first error only, fail_addr/fail_data capture the stage address and readdata.
- Latency: with start sampled at edge 0, done is high in cycle 2*DEPTH+READ_LATENCY+1 (no pause).
- pause=1: clken=0. FSM, address, LFSR and compare pipeline all hold; bus outputs keep their values. Pause in IDLE has no effect.
- start while busy: ignored. start coincident with DONE: ignored.
- Address wrap: address never exceeds DEPTH-1. DEPTH=1 is legal.

Optional Feature:
- Macro MEMTEST_INVERT_PASS_EN.
- Defined: after the first READ/DRAIN completes, the FSM repeats WRITE/READ/DRAIN with writedata and expected = ~LFSR. err_count accumulates across both passes; done latency becomes 2*(2*DEPTH+READ_LATENCY)+1.
- Undefined: single pass only.

Decomposition:
- Package onchip_mem_test_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - LFSR_TAPS constant 32'h80200003
  - function lfsr_next
  - ERR_MAX constant
- Sub-module onchip_mem_test_lfsr: seed load, advance enable, value output.

Test Plan:
- DEPTH=4, SEED=1, ideal RAM model -> writes 0x00000001, 0x80200003, … at addresses 0..3; done at cycle 10; pass=1, err_count=0.
- Model corrupts address 2 readdata with bit0 flipped -> err_count=1, fail_addr=2, fail_data = expected^1, pass=0.
- pause held 3 cycles mid-WRITE at address 1 -> clken=0 for 3 cycles, address stays 1, done delayed to cycle 13, pass=1.
- reset_n low during READ -> chipselect=0 asynchronously, busy=0, done never pulses; a later start runs cleanly to pass=1.
- Model returns 0 for all reads, DEPTH=4 -> err_count=4, fail_addr=0; start pulse while busy has no effect.
- With MEMTEST_INVERT_PASS_EN, DEPTH=4 -> second pass writes 0xFFFFFFFE first; done at cycle 19; pass=1.
